// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Multi-cycle data-memory target for LW/SW accesses. Accepts one
//             request over a valid/ready handshake, waits LATENCY cycles,
//             then returns load data or a store completion over a second
//             valid/ready handshake. Out-of-range addresses return rsp_err.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst            : clock (rising edge), synchronous active-high reset
//    req_valid/req_ready : request handshake
//    req_we              : 1 = store, 0 = load
//    req_addr            : 32-bit word address, range-checked in full
//    req_wdata           : store data
//    rsp_valid/rsp_ready : response handshake
//    rsp_rdata           : load data (0 for stores and errors)
//    rsp_err             : address out of range
//    txn_count           : completed responses, wraps 255 -> 0
//    probe_addr/_data    : side-effect-free combinational memory observation
// ============================================================================
module dmem_responder #(
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 5,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [7:0]        txn_count,
  input  logic [ADDR_W-1:0] probe_addr,
  output logic [31:0]       probe_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Counter starts at LATENCY-1 so the RESP-entry edge is LATENCY edges
  // after the accept edge.
  localparam logic [3:0] c_cnt_init = 4'(LATENCY - 1);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_mem [DEPTH];
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [31:0]         r_rsp_rdata;
  logic                r_rsp_err;
  logic [7:0]          r_txn_count;

  logic                w_in_range;
  logic [ADDR_W-1:0]   w_idx;

  // Full 32-bit compare: any bit at or above ADDR_W flags an error rather
  // than aliasing into the array.
  assign w_in_range = (r_addr < 32'(DEPTH));
  assign w_idx      = r_addr[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
      r_txn_count <= 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'(i);
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_cnt       <= c_cnt_init;
            r_req_ready <= 1'b0;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            if (!w_in_range) begin
              r_rsp_rdata <= 32'd0;
              r_rsp_err   <= 1'b1;
            end else if (r_we) begin
              r_mem[w_idx] <= r_wdata;
              r_rsp_rdata  <= 32'd0;
              r_rsp_err    <= 1'b0;
            end else begin
              r_rsp_rdata <= r_mem[w_idx];
              r_rsp_err   <= 1'b0;
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_txn_count <= r_txn_count + 8'd1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_err    = r_rsp_err;
  assign txn_count  = r_txn_count;
  assign probe_data = r_mem[probe_addr];

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Self-checking bench for dmem_responder (LATENCY=2). Expected
//             responses come from a bench-side memory model and are queued
//             at request time, then popped when the response appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int c_depth   = 32;
  localparam int c_addr_w  = 5;
  localparam int c_latency = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                req_valid;
  logic                req_we;
  logic [31:0]         req_addr;
  logic [31:0]         req_wdata;
  logic                req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_rdata;
  logic                rsp_err;
  logic [7:0]          txn_count;
  logic [c_addr_w-1:0] probe_addr;
  logic [31:0]         probe_data;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] exp_mem [c_depth];
  logic [7:0]  exp_txn;
  int          checks = 0;
  int          errors = 0;

  dmem_responder #(
    .DEPTH  (c_depth),
    .ADDR_W (c_addr_w),
    .LATENCY(c_latency)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .txn_count (txn_count),
    .probe_addr(probe_addr),
    .probe_data(probe_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < c_depth; i++) exp_mem[i] = 32'(i);
    exp_txn = 8'd0;
    exp_q.delete();
  endtask

  // Waits for req_ready, drives one request for a single accept edge, and
  // queues the model's expected response.
  task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int   n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_req_timeout: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    e.err   = (addr >= 32'(c_depth));
    e.rdata = (!we && !e.err) ? exp_mem[addr[c_addr_w-1:0]] : 32'd0;
    if (we && !e.err) exp_mem[addr[c_addr_w-1:0]] = wdata;
    exp_q.push_back(e);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    ok = (rsp_valid === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    probe_addr = 5'd7;
    model_reset();
    step(); step();
    rst = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
    checks++; if (txn_count !== 8'd0) begin errors++; $display("FAIL reset_txn_count: got %0d required 0", txn_count); end
    checks++; if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_fields: rdata=%h err=%b required 0/0", rsp_rdata, rsp_err); end
    checks++; if (probe_data !== exp_mem[7]) begin errors++; $display("FAIL reset_probe7: got %h required %h", probe_data, exp_mem[7]); end
  endtask

  task automatic test_load_timing();
    exp_t e;
    int   low;
    int   vcyc;
    send_req(1'b0, 32'd5, 32'd0);
    low  = 0;
    vcyc = -1;
    for (int c = 0; c < 12; c++) begin
      if (req_ready === 1'b1) break;
      low++;
      if (rsp_valid === 1'b1 && vcyc < 0) begin
        vcyc = c;
        e = exp_q.pop_front();
        checks++; if (rsp_rdata !== e.rdata) begin errors++; $display("FAIL load5_rdata: got %h required %h", rsp_rdata, e.rdata); end
        checks++; if (rsp_err !== e.err) begin errors++; $display("FAIL load5_err: got %b required %b", rsp_err, e.err); end
        exp_txn++;
      end
      step();
    end
    checks++; if (vcyc != c_latency) begin errors++; $display("FAIL load5_valid_cycle: got %0d required %0d", vcyc, c_latency); end
    checks++; if (low != c_latency + 1) begin errors++; $display("FAIL load5_ready_low: got %0d required %0d", low, c_latency + 1); end
    checks++; if (txn_count !== exp_txn) begin errors++; $display("FAIL load5_txn_count: got %0d required %0d", txn_count, exp_txn); end
  endtask

  task automatic test_store_load();
    exp_t e;
    bit   ok;
    probe_addr = 5'd2;
    send_req(1'b1, 32'd2, 32'hDEADBEEF);
    wait_rsp(ok);
    checks++; if (!ok) begin errors++; $display("FAIL store2_timeout: rsp_valid=%b required 1", rsp_valid); end
    e = exp_q.pop_front();
    checks++; if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin errors++; $display("FAIL store2_rsp: rdata=%h err=%b required %h/%b", rsp_rdata, rsp_err, e.rdata, e.err); end
    checks++; if (probe_data !== exp_mem[2]) begin errors++; $display("FAIL store2_probe: got %h required %h", probe_data, exp_mem[2]); end
    exp_txn++;
    step();
    send_req(1'b0, 32'd2, 32'd0);
    wait_rsp(ok);
    e = exp_q.pop_front();
    checks++; if (!ok || rsp_rdata !== e.rdata || rsp_err !== e.err) begin errors++; $display("FAIL load2_rsp: valid=%b rdata=%h err=%b required 1/%h/%b", rsp_valid, rsp_rdata, rsp_err, e.rdata, e.err); end
    exp_txn++;
    step();
    checks++; if (txn_count !== exp_txn) begin errors++; $display("FAIL store_load_txn: got %0d required %0d", txn_count, exp_txn); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit   ok;
    int   bad;
    rsp_ready = 1'b0;
    send_req(1'b0, 32'd9, 32'd0);
    wait_rsp(ok);
    e = exp_q.pop_front();
    bad = 0;
    // Requester keeps poking a store to addr 0; it must not be accepted.
    for (int c = 0; c < 5; c++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err || req_ready !== 1'b0) bad++;
      req_valid = (c % 2 == 0);
      req_we    = 1'b1;
      req_addr  = 32'd0;
      req_wdata = 32'hBAD0BAD0;
      step();
    end
    checks++; if (!ok || bad != 0) begin errors++; $display("FAIL bp_hold: unstable samples=%0d ok=%b rdata=%h required %h", bad, ok, rsp_rdata, e.rdata); end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    exp_txn++;
    step();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release: valid=%b ready=%b required 0/1", rsp_valid, req_ready); end
    step(); step();
    checks++; if (txn_count !== exp_txn) begin errors++; $display("FAIL bp_single_completion: got %0d required %0d", txn_count, exp_txn); end
    probe_addr = 5'd0;
    checks++; if (probe_data !== exp_mem[0]) begin errors++; $display("FAIL bp_ignored_store: mem0=%h required %h", probe_data, exp_mem[0]); end
  endtask

  task automatic test_errors();
    exp_t e;
    bit   ok;
    send_req(1'b0, 32'd32, 32'd0);
    wait_rsp(ok);
    e = exp_q.pop_front();
    checks++; if (!ok || rsp_err !== e.err || rsp_rdata !== e.rdata) begin errors++; $display("FAIL err_load32: err=%b rdata=%h required %b/%h", rsp_err, rsp_rdata, e.err, e.rdata); end
    exp_txn++;
    step();
    send_req(1'b1, 32'h80000001, 32'h55AA55AA);
    wait_rsp(ok);
    e = exp_q.pop_front();
    checks++; if (!ok || rsp_err !== e.err || rsp_rdata !== e.rdata) begin errors++; $display("FAIL err_store_high: err=%b rdata=%h required %b/%h", rsp_err, rsp_rdata, e.err, e.rdata); end
    exp_txn++;
    step();
    probe_addr = 5'd1;
    checks++; if (probe_data !== exp_mem[1]) begin errors++; $display("FAIL err_mem1: got %h required %h", probe_data, exp_mem[1]); end
    checks++; if (txn_count !== exp_txn) begin errors++; $display("FAIL err_txn_count: got %0d required %0d", txn_count, exp_txn); end
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    send_req(1'b1, 32'd3, 32'h12345678);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid === 1'b1) seen++;
      step();
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_rsp: valid cycles=%0d required 0", seen); end
    probe_addr = 5'd3;
    checks++; if (probe_data !== exp_mem[3]) begin errors++; $display("FAIL midrst_mem3: got %h required %h", probe_data, exp_mem[3]); end
    checks++; if (txn_count !== exp_txn) begin errors++; $display("FAIL midrst_txn: got %0d required %0d", txn_count, exp_txn); end
  endtask

  task automatic test_wrap();
    exp_t e;
    bit   ok;
    int   bad;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      send_req(1'b0, 32'(i % 40), 32'd0);
      wait_rsp(ok);
      e = exp_q.pop_front();
      if (!ok || rsp_rdata !== e.rdata || rsp_err !== e.err) bad++;
      exp_txn++;
      step();
      if (i == 254) begin
        checks++; if (txn_count !== exp_txn) begin errors++; $display("FAIL wrap_255: got %0d required %0d", txn_count, exp_txn); end
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL wrap_rsp_data: bad responses=%0d required 0", bad); end
    checks++; if (txn_count !== exp_txn) begin errors++; $display("FAIL wrap_zero: got %0d required %0d", txn_count, exp_txn); end
  endtask

  initial begin
    test_reset();
    test_load_timing();
    test_store_load();
    test_backpressure();
    test_errors();
    test_reset_mid_wait();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory target for the datapath's LW/SW accesses.
- Accepts one load or store request per transaction over a valid/ready handshake and waits a programmable number of cycles.
- Returns read data or a completion response over a second valid/ready handshake.
- Replaces the zero-latency data memory so the upcoming multi-cycle controller can be exercised against a slow memory. A probe port gives lab/display observation.

Parameters:
- DEPTH, 32, number of 32-bit words.
- ADDR_W, 5, word-index width; DEPTH must equal 2**ADDR_W.
- LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_we  input  1  1 = store (SW), 0 = load (LW)
- req_addr  input  32  word address (the ALU result)
- req_wdata  input  32  store data (RD2)
- req_ready  output  1  responder can accept a request
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester consumes the response
- rsp_rdata  output  32  load data; 0 for stores and errors
- rsp_err  output  1  address out of range (req_addr >= DEPTH)
- txn_count  output  8  completed responses, wraps 255 -> 0
- probe_addr  input  ADDR_W  observation index
- probe_data  output  32  mem[probe_addr], combinational, no side effects

Behaviour:
- Reset, synchronous, active-high, takes priority over everything:
  - state = IDLE.
  - mem[i] = i for all i.
  - Outputs: req_ready=1 (IDLE), rsp_valid=0, rsp_rdata=0, rsp_err=0, txn_count=0.
  - Latched request fields cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1, rsp_valid=0.
  - At an edge where req_valid=1, latch we, addr and wdata; load cnt=LATENCY-1; go to WAIT.
- WAIT:
  - req_ready=0, rsp_valid=0.
  - req_* inputs are ignored; latched values are used.
  - At each edge: if cnt!=0, cnt--. If cnt==0, go to RESP and perform the access:
    - In range, load: rsp_rdata <= mem[addr]; rsp_err <= 0.
    - In range, store: mem[addr] <= wdata; rsp_rdata <= 0; rsp_err <= 0.
    - Out of range: no memory write; rsp_rdata <= 0; rsp_err <= 1.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata and rsp_err are held stable while rsp_ready=0.
  - At an edge with rsp_ready=1: txn_count++ (wrapping); go to IDLE; rsp_rdata and rsp_err are cleared to 0.
- Timing: a request accepted at edge k gives rsp_valid=1 in the cycle after edge k+LATENCY. With rsp_ready held at 1, req_ready returns one cycle after that. Throughput is one transaction per LATENCY+2 cycles; there are no overlapping transactions.
- Range check: uses the full 32-bit req_addr. An address with any bit set at position ADDR_W or above is an error. There is no silent truncation.
- probe_data: reflects a store starting the cycle after the RESP-entry edge.
- Reset mid-operation, in WAIT or RESP:
  - The transaction is aborted with no response.
  - Any store already performed is overwritten by re-initialisation.
  - txn_count is not incremented.
- rsp_ready=1 outside RESP has no effect.
- req_valid=1 during WAIT/RESP is not accepted; the requester must hold it until req_ready.

Test Plan:
1. Reset check, LATENCY=2: assert rst for 2 cycles -> req_ready=1, rsp_valid=0, txn_count=0, probe_addr=7 gives probe_data=7.
2. Load timing, LATENCY=2: load at addr 5 with rsp_ready=1 -> req_ready=0 for 3 cycles; rsp_valid=1 exactly 2 cycles after the accept edge with rsp_rdata=5, rsp_err=0; txn_count=1.
3. Store then load: store 0xDEADBEEF to addr 2, then load addr 2 -> store response has rsp_rdata=0; probe_addr=2 reads 0xDEADBEEF; load returns 0xDEADBEEF.
4. Backpressure: hold rsp_ready=0 for 5 cycles on a load of addr 9 -> rsp_valid and rsp_rdata=9 stable for all 5 cycles; req_valid pulses ignored; a single completion when rsp_ready rises.
5. Errors: load addr 32 and store to addr 0x80000001 -> rsp_err=1, rsp_rdata=0; memory unchanged (probe addr 1 reads 1); txn_count still increments.
6. Reset mid-WAIT: accept a store to addr 3, assert rst the next cycle -> no rsp_valid, mem[3]=3, txn_count=0. Also run 256 transactions -> txn_count wraps to 0.
